// File: rtl/bruteforce_gen.sv
// Candidate-string generator: enumerates all strings over [CHAR_LO, CHAR_HI],
//   shortest first, rightmost char fastest, advancing `stride` candidates per accept.
// Latency: first candidate 1 cycle after start; next candidate stride+1 cycles after accept.
// Backpressure: password/num_chars held stable while out_valid && !out_ready.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   enable              gates stepping between candidates (STEP only)
//   start, start_char,  single-cycle restart with first candidate and stride
//   stride
//   out_valid/out_ready candidate handshake; password right-aligned, num_chars length
//   count, done         accepted-candidate count (saturating), search exhausted
module bruteforce_gen #(
    parameter int         MAX_LEN  = 16,
    parameter logic [7:0] CHAR_LO  = 8'd97,
    parameter logic [7:0] CHAR_HI  = 8'd122,
    parameter int         STRIDE_W = 3,
    parameter int         CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic [7:0]             start_char,
    input  logic [STRIDE_W-1:0]    stride,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [MAX_LEN*8-1:0]   password,
    output logic [7:0]             num_chars,
    output logic [CNT_W-1:0]       count,
    output logic                   done
);
    localparam int         PW_W      = MAX_LEN * 8;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, VALID, STEP, DONE} state_t;

    state_t              state, state_n;
    // work_* walks through skipped candidates; password/num_chars only change
    // when a new candidate is presented, so an exhausting stride leaves the
    // last emitted value visible.
    logic [PW_W-1:0]     work_pw, work_pw_n, password_n, inc_pw;
    logic [7:0]          work_len, work_len_n, num_chars_n, inc_len;
    logic [CNT_W-1:0]    count_n;
    logic [STRIDE_W-1:0] stride_q, stride_q_n, step_cnt, step_cnt_n;
    logic                inc_exhaust;
    logic                carry;
    logic                start_ok;

    assign start_ok  = (start_char >= CHAR_LO) && (start_char <= CHAR_HI);
    assign out_valid = (state == VALID);
    assign done      = (state == DONE);

    // Successor of the working candidate. Position 0 is the rightmost char.
    always_comb begin
        inc_pw      = work_pw;
        inc_len     = work_len;
        inc_exhaust = 1'b0;
        carry       = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (carry && (i < int'(work_len))) begin
                if (work_pw[i*8 +: 8] == CHAR_HI) begin
                    inc_pw[i*8 +: 8] = CHAR_LO;
                end else begin
                    inc_pw[i*8 +: 8] = work_pw[i*8 +: 8] + 8'd1;
                    carry            = 1'b0;
                end
            end
        end
        if (carry) begin
            if (work_len == MAX_LEN_B) begin
                inc_exhaust = 1'b1;
            end else begin
                // Grow by one char; every active position restarts at CHAR_LO.
                inc_len = work_len + 8'd1;
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (i <= int'(work_len)) begin
                        inc_pw[i*8 +: 8] = CHAR_LO;
                    end
                end
            end
        end
    end

    always_comb begin
        state_n     = state;
        work_pw_n   = work_pw;
        work_len_n  = work_len;
        password_n  = password;
        num_chars_n = num_chars;
        count_n     = count;
        stride_q_n  = stride_q;
        step_cnt_n  = step_cnt;

        if (start) begin
            stride_q_n       = (stride == '0) ? STRIDE_W'(1) : stride;
            work_pw_n        = '0;
            work_pw_n[7:0]   = start_ok ? start_char : CHAR_LO;
            work_len_n       = 8'd1;
            password_n       = '0;
            password_n[7:0]  = start_ok ? start_char : CHAR_LO;
            num_chars_n      = 8'd1;
            count_n          = '0;
            step_cnt_n       = '0;
            state_n          = VALID;
        end else begin
            case (state)
                VALID: begin
                    if (out_ready) begin
                        count_n = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
                        // The final candidate has no successor.
                        if (inc_exhaust) begin
                            state_n = DONE;
                        end else begin
                            step_cnt_n = stride_q;
                            state_n    = STEP;
                        end
                    end
                end
                STEP: begin
                    if (enable) begin
                        if (inc_exhaust) begin
                            state_n = DONE;
                        end else begin
                            work_pw_n  = inc_pw;
                            work_len_n = inc_len;
                            step_cnt_n = step_cnt - STRIDE_W'(1);
                            // Last step lands on the next candidate to present.
                            if (step_cnt == STRIDE_W'(1)) begin
                                password_n  = inc_pw;
                                num_chars_n = inc_len;
                                state_n     = VALID;
                            end
                        end
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            work_pw   <= '0;
            work_len  <= '0;
            password  <= '0;
            num_chars <= '0;
            count     <= '0;
            stride_q  <= '0;
            step_cnt  <= '0;
        end else begin
            state     <= state_n;
            work_pw   <= work_pw_n;
            work_len  <= work_len_n;
            password  <= password_n;
            num_chars <= num_chars_n;
            count     <= count_n;
            stride_q  <= stride_q_n;
            step_cnt  <= step_cnt_n;
        end
    end
endmodule
